// File: rtl/wishbone_slave_adapter_periph.sv
// Wishbone B4 classic slave adapter to a request/ready peripheral port with base/mask decode.
// Define WB_ADAPTER_TIMEOUT_EN to add a REQ-state timeout that reports a bus error.
module wishbone_slave_adapter_periph #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [AW-1:0] BASE_ADDR = 32'h2000_0000,
  parameter logic [AW-1:0] ADDR_MASK = 32'hFFFF_0000,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [DW-1:0]   wb_data_i,
  output logic [DW-1:0]   wb_data_o,
  input  logic            wb_we_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            periph_req_o,
  output logic            periph_we_o,
  output logic [DW/8-1:0] periph_be_o,
  output logic [AW-1:0]   periph_addr_o,
  output logic [DW-1:0]   periph_wdata_o,
  input  logic [DW-1:0]   periph_rdata_i,
  input  logic            periph_ready_i
);

  typedef enum logic [2:0] {IDLE, REQ, ACK, ERR, COOLDOWN} state_t;

  state_t state;
  logic   hit;

  if (DW % 8 != 0) begin : g_dw_check
    $error("DW must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_to_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign hit = ((wb_addr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

`ifdef WB_ADAPTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] to_cnt;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wb_data_o      <= '0;
      wb_ack_o       <= 1'b0;
      wb_err_o       <= 1'b0;
      periph_req_o   <= 1'b0;
      periph_we_o    <= 1'b0;
      periph_be_o    <= '0;
      periph_addr_o  <= '0;
      periph_wdata_o <= '0;
`ifdef WB_ADAPTER_TIMEOUT_EN
      to_cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            periph_addr_o  <= wb_addr_i & ~ADDR_MASK;
            periph_we_o    <= wb_we_i;
            periph_be_o    <= wb_sel_i;
            periph_wdata_o <= wb_data_i;
            if (hit) begin
              state        <= REQ;
              periph_req_o <= 1'b1;
`ifdef WB_ADAPTER_TIMEOUT_EN
              to_cnt       <= '0;
`endif
            end else begin
              state    <= ERR;
              wb_err_o <= 1'b1;
            end
          end
        end
        REQ: begin
          // A master abort takes priority over a same-cycle ready.
          if (!wb_cyc_i) begin
            state        <= IDLE;
            periph_req_o <= 1'b0;
          end else if (periph_ready_i) begin
            state        <= ACK;
            periph_req_o <= 1'b0;
            wb_ack_o     <= 1'b1;
            if (!periph_we_o) wb_data_o <= periph_rdata_i;
          end
`ifdef WB_ADAPTER_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state        <= ERR;
            periph_req_o <= 1'b0;
            wb_err_o     <= 1'b1;
            to_cnt       <= to_cnt + 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ACK: begin
          wb_ack_o <= 1'b0;
          state    <= COOLDOWN;
        end
        ERR: begin
          wb_err_o <= 1'b0;
          state    <= COOLDOWN;
        end
        COOLDOWN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_slave_adapter_periph.sv
// Self-checking bench: vector table of bus accesses plus abort, back-to-back, timeout and reset sequences.
module tb_wishbone_slave_adapter_periph;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [31:0] wb_addr_i, wb_data_i, wb_data_o, periph_rdata_i, periph_wdata_o, periph_addr_o;
  logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o, wb_err_o;
  logic [3:0]  wb_sel_i, periph_be_o;
  logic        periph_req_o, periph_we_o, periph_ready_i;

  wishbone_slave_adapter_periph dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_data_o(wb_data_o),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .periph_req_o(periph_req_o), .periph_we_o(periph_we_o), .periph_be_o(periph_be_o),
    .periph_addr_o(periph_addr_o), .periph_wdata_o(periph_wdata_o),
    .periph_rdata_i(periph_rdata_i), .periph_ready_i(periph_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic        miss;
    logic [31:0] off;
  } vec_t;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  vec_t        vecs[7];
  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          ack_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock; sample #1 after the edge and retire any completion against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk_i);
    #1;
    if (wb_ack_o) ack_cnt++;
    if (wb_err_o) err_cnt++;
    if (wb_ack_o || wb_err_o) begin
      chk("ack_err_exclusive", 32'(wb_ack_o & wb_err_o), 32'd0);
      if (sb.size() == 0) begin
        chk("sb_unexpected_completion", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("sb_err", 32'(wb_err_o), 32'(e.is_err));
        chk("sb_ack", 32'(wb_ack_o), 32'(!e.is_err));
        chk("sb_data", wb_data_o, e.data);
      end
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    wb_addr_i = v.addr; wb_we_i = v.we; wb_sel_i = v.sel; wb_data_i = v.wdata;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; periph_ready_i = 1'b0;
    e.is_err = v.miss;
    if (!v.miss && !v.we) last_data = v.rdata;
    e.data = last_data;
    sb.push_back(e);
  endtask

  task automatic xact(input vec_t v);
    drive(v);
    step();
    if (v.miss) begin
      chk("miss_err_n1", 32'(wb_err_o), 32'd1);
      chk("miss_no_req", 32'(periph_req_o), 32'd0);
    end else begin
      for (int k = 1; k <= v.lat; k++) begin
        chk("req_high", 32'(periph_req_o), 32'd1);
        chk("req_we", 32'(periph_we_o), 32'(v.we));
        chk("req_addr", periph_addr_o, v.off);
        chk("req_be", 32'(periph_be_o), 32'(v.sel));
        chk("req_wdata", periph_wdata_o, v.wdata);
        chk("no_early_ack", 32'(wb_ack_o), 32'd0);
        if (k == v.lat) begin
          periph_ready_i = 1'b1;
          periph_rdata_i = v.rdata;
        end
        step();
      end
      chk("ack_after_ready", 32'(wb_ack_o), 32'd1);
      chk("req_dropped", 32'(periph_req_o), 32'd0);
      periph_ready_i = 1'b0;
      periph_rdata_i = 32'h5555_AAAA;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
    chk("cooldown_quiet", 32'(wb_ack_o | wb_err_o), 32'd0);
    step();
    chk("data_held", wb_data_o, last_data);
  endtask

  initial begin
    vec_t v;
    int   a0, e0, reqs;
    rst_n = 1'b0;
    wb_addr_i = '0; wb_data_i = '0; wb_we_i = 1'b0; wb_sel_i = '0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; periph_rdata_i = '0; periph_ready_i = 1'b0;

    vecs[0] = '{32'h2000_0010, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, 32'h0000_0010};
    vecs[1] = '{32'h2000_0004, 1'b0, 4'b1111, 32'h0,         32'h1234_5678, 5, 1'b0, 32'h0000_0004};
    vecs[2] = '{32'h3000_0000, 1'b0, 4'b1111, 32'h0,         32'h0, 1, 1'b1, 32'h0};
    vecs[3] = '{32'h2000_FFFC, 1'b1, 4'b1100, 32'hA5A5_0F0F, 32'h0, 3, 1'b0, 32'h0000_FFFC};
    vecs[4] = '{32'h2000_0000, 1'b0, 4'b0001, 32'h0,         32'hCAFE_F00D, 1, 1'b0, 32'h0000_0000};
    vecs[5] = '{32'h1FFF_FFFC, 1'b1, 4'b1111, 32'h1111_2222, 32'h0, 1, 1'b1, 32'h0};
    vecs[6] = '{32'h2001_0000, 1'b0, 4'b1111, 32'h0,         32'h0, 1, 1'b1, 32'h0};

    #12;
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_err", 32'(wb_err_o), 32'd0);
    chk("rst_req", 32'(periph_req_o), 32'd0);
    chk("rst_we", 32'(periph_we_o), 32'd0);
    chk("rst_rdata", wb_data_o, 32'd0);
    chk("rst_be", 32'(periph_be_o), 32'd0);
    chk("rst_addr", periph_addr_o, 32'd0);
    chk("rst_wdata", periph_wdata_o, 32'd0);
    #5 rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) xact(vecs[i]);

    // Abort in the 3rd REQ cycle with ready in the same cycle: no ack, data unchanged.
    a0 = ack_cnt; e0 = err_cnt;
    wb_addr_i = 32'h2000_0008; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    step();
    step();
    step();
    chk("abort_req_3rd", 32'(periph_req_o), 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    periph_ready_i = 1'b1; periph_rdata_i = 32'hBBBB_BBBB;
    step();
    periph_ready_i = 1'b0;
    chk("abort_req_low", 32'(periph_req_o), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
    chk("abort_no_err", 32'(err_cnt - e0), 32'd0);
    chk("abort_data", wb_data_o, last_data);

    // Master keeps stb asserted after ack: next acceptance lands 3 cycles after the ack cycle.
    v = '{32'h2000_0020, 1'b1, 4'b1111, 32'h0BAD_F00D, 32'h0, 1, 1'b0, 32'h0000_0020};
    drive(v);
    step();
    periph_ready_i = 1'b1;
    step();
    chk("b2b_ack", 32'(wb_ack_o), 32'd1);
    periph_ready_i = 1'b0;
    step();
    chk("b2b_cool_noreq", 32'(periph_req_o), 32'd0);
    step();
    chk("b2b_idle_noreq", 32'(periph_req_o), 32'd0);
    step();
    chk("b2b_reaccept", 32'(periph_req_o), 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
    step();

`ifdef WB_ADAPTER_TIMEOUT_EN
    v = '{32'h2000_0040, 1'b0, 4'b1111, 32'h0, 32'h0, 1, 1'b1, 32'h0};
    drive(v);
    v.miss = 1'b0;
    reqs = 0;
    step();
    for (int i = 0; i < 40; i++) begin
      if (periph_req_o) reqs++;
      if (wb_err_o) break;
      step();
    end
    chk("timeout_err", 32'(wb_err_o), 32'd1);
    chk("timeout_req_cycles", 32'(reqs), 32'd16);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
    chk("timeout_err_pulse", 32'(wb_err_o), 32'd0);
    step();
`else
    e0 = err_cnt; a0 = ack_cnt;
    wb_addr_i = 32'h2000_0040; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 101; i++) step();
    chk("hold_req_100", 32'(periph_req_o), 32'd1);
    chk("hold_no_err", 32'(err_cnt - e0), 32'd0);
    chk("hold_no_ack", 32'(ack_cnt - a0), 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
    step();
`endif

    // Reset asserted mid-REQ clears everything without waiting for a clock.
    a0 = ack_cnt;
    wb_addr_i = 32'h2000_0100; wb_we_i = 1'b1; wb_sel_i = 4'b0101; wb_data_i = 32'h7777_7777;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    step();
    chk("mid_req_high", 32'(periph_req_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(periph_req_o), 32'd0);
    chk("arst_we", 32'(periph_we_o), 32'd0);
    chk("arst_be", 32'(periph_be_o), 32'd0);
    chk("arst_addr", periph_addr_o, 32'd0);
    chk("arst_wdata", periph_wdata_o, 32'd0);
    chk("arst_rdata", wb_data_o, 32'd0);
    chk("arst_ackerr", 32'(wb_ack_o | wb_err_o), 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    periph_ready_i = 1'b1;
    #10 rst_n = 1'b1;
    last_data = '0;
    for (int i = 0; i < 3; i++) step();
    periph_ready_i = 1'b0;
    chk("arst_no_ack", 32'(ack_cnt - a0), 32'd0);

    // Read after reset to confirm normal operation resumes.
    xact('{32'h2000_0200, 1'b0, 4'b1111, 32'h0, 32'h600D_CAFE, 2, 1'b0, 32'h0000_0200});

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
